// File: rtl/lfsr_bist_pkg.sv
// Shared constants for the LFSR BIST sequencer: state encoding, word geometry
// and the seed substitution used to keep the LFSR out of its lock-up state.
package lfsr_bist_pkg;

  localparam int WORD_W = 32;
  localparam int IDX_W  = $clog2(WORD_W);
  localparam int BITS_W = IDX_W + 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_FLUSH = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [WORD_W-1:0] SEED_SUB = 32'h1;

  // An all-zero LFSR never leaves zero, so such a seed is swapped for SEED_SUB.
  function automatic logic [WORD_W-1:0] safeSeed(input logic [WORD_W-1:0] seed);
    return (seed == '0) ? SEED_SUB : seed;
  endfunction

endpackage

// File: rtl/bist_word_packer.sv
// Packs a serial bitstream LSB-first into words and presents them through a
// single output register with a valid/ready handshake.
module bist_word_packer
  import lfsr_bist_pkg::*;
(
  input  logic              Clk,
  input  logic              ARst,
  input  logic              clear_i,
  input  logic              shiftEn_i,
  input  logic              bit_i,
  input  logic              lastBit_i,
  input  logic              flush_i,
  input  logic              wordReady_i,
  output logic              full_o,
  output logic              canLoad_o,
  output logic              wordValid_o,
  output logic [WORD_W-1:0] wordData_o,
  output logic              wordLast_o,
  output logic [BITS_W-1:0] wordBits_o
);

  logic [WORD_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              outValid_q, outValid_d;
  logic [WORD_W-1:0] outData_q, outData_d;
  logic              outLast_q, outLast_d;
  logic [BITS_W-1:0] outBits_q, outBits_d;
  logic              wordDone;

  assign full_o    = (idx_q == IDX_W'(WORD_W - 1));
  assign canLoad_o = !outValid_q || wordReady_i;
  assign wordDone  = shiftEn_i && full_o;

  // The completing bit goes straight into the output word; clear only discards the partial word.
  always_comb begin
    shift_d    = shift_q;
    idx_d      = idx_q;
    outValid_d = outValid_q;
    outData_d  = outData_q;
    outLast_d  = outLast_q;
    outBits_d  = outBits_q;
    if (outValid_q && wordReady_i) outValid_d = 1'b0;
    if (wordDone) begin
      outValid_d = 1'b1;
      outData_d  = {bit_i, shift_q[WORD_W-2:0]};
      outLast_d  = lastBit_i;
      outBits_d  = BITS_W'(WORD_W);
      shift_d    = '0;
      idx_d      = '0;
    end else if (flush_i) begin
      outValid_d = 1'b1;
      outData_d  = shift_q;
      outLast_d  = 1'b1;
      outBits_d  = {1'b0, idx_q};
      shift_d    = '0;
      idx_d      = '0;
    end else if (shiftEn_i) begin
      shift_d[idx_q] = bit_i;
      idx_d          = idx_q + IDX_W'(1);
    end
    if (clear_i) begin
      shift_d = '0;
      idx_d   = '0;
    end
  end

  always_ff @(posedge Clk or posedge ARst) begin
    if (ARst) begin
      shift_q    <= '0;
      idx_q      <= '0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outLast_q  <= 1'b0;
      outBits_q  <= '0;
    end else begin
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      outLast_q  <= outLast_d;
      outBits_q  <= outBits_d;
    end
  end

  assign wordValid_o = outValid_q;
  assign wordData_o  = outData_q;
  assign wordLast_o  = outLast_q;
  assign wordBits_o  = outBits_q;

endmodule

// File: rtl/lfsr_bist_ctrl.sv
// BIST sequencer for one lfsr32: loads the seed, runs the generator for the
// commanded bit count, packs its output into words and counts checker mismatches.
module lfsr_bist_ctrl
  import lfsr_bist_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter bit ERR_SAT = 1'b1
) (
  input  logic             Clk,
  input  logic             ARst,
  input  logic             CmdValid,
  output logic             CmdReady,
  input  logic [31:0]      CmdSeed,
  input  logic [CNT_W-1:0] CmdLen,
  input  logic             Abort,
  output logic             LfsrLoad,
  output logic             LfsrEnable,
  output logic [31:0]      LfsrSeed,
  input  logic             LFSR0in,
  input  logic             LFSR1in,
  output logic             WordValid,
  input  logic             WordReady,
  output logic [31:0]      WordData,
  output logic             WordLast,
  output logic [5:0]       WordBits,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] ErrCount
);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [31:0]      seed_q, seed_d;
  logic             enable, packClear, packFlush, packFull, packCanLoad, lastBit;

  assign lastBit = (rem_q == CNT_W'(1));

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    err_d     = err_q;
    seed_d    = seed_q;
    enable    = 1'b0;
    packClear = 1'b0;
    packFlush = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (CmdValid) begin
          rem_d     = CmdLen;
          err_d     = '0;
          seed_d    = safeSeed(CmdSeed);
          packClear = 1'b1;
          state_d   = (CmdLen != '0) ? ST_LOAD : ST_DONE;
        end
      end
      ST_LOAD: begin
        state_d = ST_RUN;
        if (Abort) begin
          state_d   = ST_DONE;
          packClear = 1'b1;
        end
      end
      ST_RUN: begin
        // A full word may only complete when the output register can take it; otherwise the LFSR is held.
        enable = !(packFull && !packCanLoad);
        if (enable) begin
          rem_d = rem_q - CNT_W'(1);
          if ((LFSR0in != LFSR1in) && (!ERR_SAT || (err_q != '1)))
            err_d = err_q + CNT_W'(1);
          if (lastBit) state_d = packFull ? ST_DONE : ST_FLUSH;
        end
        if (Abort) begin
          state_d   = ST_DONE;
          packClear = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (Abort) begin
          state_d   = ST_DONE;
          packClear = 1'b1;
        end else if (packCanLoad) begin
          packFlush = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge ARst) begin
    if (ARst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      err_q   <= '0;
      seed_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      seed_q  <= seed_d;
    end
  end

  bist_word_packer u_packer (
    .Clk         (Clk),
    .ARst        (ARst),
    .clear_i     (packClear),
    .shiftEn_i   (enable),
    .bit_i       (LFSR0in),
    .lastBit_i   (lastBit),
    .flush_i     (packFlush),
    .wordReady_i (WordReady),
    .full_o      (packFull),
    .canLoad_o   (packCanLoad),
    .wordValid_o (WordValid),
    .wordData_o  (WordData),
    .wordLast_o  (WordLast),
    .wordBits_o  (WordBits)
  );

  assign CmdReady   = (state_q == ST_IDLE);
  assign LfsrLoad   = (state_q == ST_LOAD);
  assign LfsrEnable = enable;
  assign LfsrSeed   = seed_q;
  assign Busy       = (state_q != ST_IDLE);
  assign Done       = (state_q == ST_DONE);
  assign ErrCount   = err_q;

endmodule

// File: tb/tb_lfsr_bist_ctrl.sv
// Self-checking bench for lfsr_bist_ctrl: emulates lfsr32 around the DUT and
// predicts every packed word, error count and timing from the command alone.
module tb_lfsr_bist_ctrl;

  logic        Clk = 1'b0;
  logic        ARst = 1'b1;
  logic        CmdValid = 1'b0;
  logic        CmdReady;
  logic [31:0] CmdSeed = '0;
  logic [15:0] CmdLen = '0;
  logic        Abort = 1'b0;
  logic        LfsrLoad, LfsrEnable;
  logic [31:0] LfsrSeed;
  logic        LFSR0in, LFSR1in;
  logic        WordValid;
  logic        WordReady = 1'b1;
  logic [31:0] WordData;
  logic        WordLast;
  logic [5:0]  WordBits;
  logic        Busy, Done;
  logic [15:0] ErrCount;

  lfsr_bist_ctrl #(.CNT_W(16), .ERR_SAT(1'b1)) dut (
    .Clk(Clk), .ARst(ARst), .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdSeed(CmdSeed), .CmdLen(CmdLen), .Abort(Abort),
    .LfsrLoad(LfsrLoad), .LfsrEnable(LfsrEnable), .LfsrSeed(LfsrSeed),
    .LFSR0in(LFSR0in), .LFSR1in(LFSR1in),
    .WordValid(WordValid), .WordReady(WordReady), .WordData(WordData),
    .WordLast(WordLast), .WordBits(WordBits),
    .Busy(Busy), .Done(Done), .ErrCount(ErrCount)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [31:0] data;
    logic [5:0]  bits;
    logic        last;
  } word_t;

  word_t       expQ[$];
  logic [31:0] expSeed = '0;
  int          expErr = 0;
  int          tests = 0;
  int          fails = 0;
  int          readyMode = 0;
  int          holdLen = 0;
  int          holdCnt = 0;
  bit          flipArr[0:2047];

  int          cyc = 0, acceptCyc = 0, firstEn = -1, lastEn = 0, doneCyc = 0, abortCyc = -100;
  int          enCount = 0, loads = 0, doneCount = 0;
  logic [31:0] lastData = '0;
  logic [5:0]  lastBits = '0;
  logic        holdPrev = 1'b0;
  word_t       prevWord;

  // Galois form of x^32+x^22+x^2+x+1; the bit presented is the pre-shift state bit 0.
  function automatic logic [31:0] lfsrStep(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  // Stand-in for lfsr32: both generators load together and the checker copy
  // can be made to disagree on chosen bits.
  logic [31:0] envState = '0;
  logic [31:0] bitCnt = '0;
  always @(posedge Clk) begin
    if (LfsrLoad) begin
      envState <= LfsrSeed;
      bitCnt   <= '0;
    end else if (LfsrEnable) begin
      envState <= lfsrStep(envState);
      bitCnt   <= bitCnt + 32'd1;
    end
  end
  assign LFSR0in = envState[0];
  assign LFSR1in = envState[0] ^ flipArr[bitCnt[10:0]];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Consumer: always ready, randomly ready, or holding each word for holdLen cycles.
  always @(posedge Clk) begin
    #1;
    if (readyMode == 0) WordReady = 1'b1;
    else if (readyMode == 1) WordReady = ($urandom_range(0, 3) != 0);
    else if (WordValid && holdCnt < holdLen) begin
      WordReady = 1'b0;
      holdCnt++;
    end else begin
      WordReady = 1'b1;
      holdCnt = 0;
    end
  end

  // Single compare process: handshakes against the expected-word queue, hold
  // stability, seed on load and the error count at the end of each run.
  always @(negedge Clk) begin : monitor
    word_t w;
    cyc++;
    if (ARst) begin
      holdPrev = 1'b0;
    end else begin
      if (CmdValid && CmdReady) begin
        acceptCyc = cyc;
        firstEn   = -1;
        enCount   = 0;
        loads     = 0;
        abortCyc  = -100;
      end
      if (LfsrLoad) begin
        loads++;
        checkOutput("load_seed", LfsrSeed, expSeed);
      end
      if (LfsrEnable) begin
        if (firstEn < 0) firstEn = cyc;
        lastEn = cyc;
        enCount++;
      end
      if (Abort && LfsrEnable) abortCyc = cyc;
      if (holdPrev) begin
        checkOutput("hold_valid", {31'b0, WordValid}, 32'h1);
        checkOutput("hold_data", WordData, prevWord.data);
        checkOutput("hold_bits", {26'b0, WordBits}, {26'b0, prevWord.bits});
        checkOutput("hold_last", {31'b0, WordLast}, {31'b0, prevWord.last});
      end
      if (WordValid && WordReady) begin
        checkOutput("word_expected", 32'(expQ.size() > 0), 32'h1);
        if (expQ.size() > 0) begin
          w = expQ.pop_front();
          checkOutput("word_data", WordData, w.data);
          checkOutput("word_bits", {26'b0, WordBits}, {26'b0, w.bits});
          checkOutput("word_last", {31'b0, WordLast}, {31'b0, w.last});
        end
        lastData = WordData;
        lastBits = WordBits;
      end
      if (Done) begin
        doneCyc = cyc;
        doneCount++;
        checkOutput("err_count", {16'b0, ErrCount}, 32'(expErr));
      end
      holdPrev = WordValid && !WordReady;
      prevWord = '{WordData, WordBits, WordLast};
    end
  end

  task automatic checkIdleReset();
    checkOutput("rst_cmd_ready", {31'b0, CmdReady}, 32'h1);
    checkOutput("rst_busy", {31'b0, Busy}, 32'h0);
    checkOutput("rst_done", {31'b0, Done}, 32'h0);
    checkOutput("rst_load", {31'b0, LfsrLoad}, 32'h0);
    checkOutput("rst_enable", {31'b0, LfsrEnable}, 32'h0);
    checkOutput("rst_seed", LfsrSeed, 32'h0);
    checkOutput("rst_word_valid", {31'b0, WordValid}, 32'h0);
    checkOutput("rst_word_data", WordData, 32'h0);
    checkOutput("rst_word_bits", {26'b0, WordBits}, 32'h0);
    checkOutput("rst_word_last", {31'b0, WordLast}, 32'h0);
    checkOutput("rst_err", {16'b0, ErrCount}, 32'h0);
  endtask

  // Builds the expected words and mismatch count for one command, then drives
  // it (with an optional abort at enabled bit abortAt) and waits for the run to end.
  task automatic applyStimulus(input logic [31:0] seed, input int len, input int mode, input int abortAt);
    logic [31:0] s, w;
    int nb, nBits, startDone, guard;
    bit sent;
    expSeed = (seed == 32'h0) ? 32'h1 : seed;
    nBits = (abortAt >= 0) ? abortAt + 1 : len;
    for (int k = 0; k < len; k++)
      flipArr[k] = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    s = expSeed; w = '0; nb = 0; expErr = 0;
    for (int k = 0; k < nBits; k++) begin
      w[nb] = s[0];
      if (flipArr[k]) expErr++;
      s = lfsrStep(s);
      nb++;
      if (nb == 32) begin
        expQ.push_back('{w, 6'd32, 1'(k == len - 1)});
        w = '0;
        nb = 0;
      end
    end
    if (abortAt < 0 && nb != 0) expQ.push_back('{w, 6'(nb), 1'b1});

    startDone = doneCount;
    CmdSeed  = seed;
    CmdLen   = 16'(len);
    CmdValid = 1'b1;
    @(posedge Clk); #1;
    CmdValid = 1'b0;
    guard = 0;
    sent = 1'b0;
    while (doneCount == startDone && guard < 3000) begin
      Abort = (abortAt >= 0) && !sent && (enCount == abortAt) && LfsrEnable;
      if (Abort) sent = 1'b1;
      @(posedge Clk); #1;
      guard++;
    end
    Abort = 1'b0;
    checkOutput("done_seen", 32'(doneCount - startDone), 32'h1);
    checkOutput("idle_ready", {31'b0, CmdReady}, 32'h1);
    guard = 0;
    while (expQ.size() != 0 && guard < 300) begin
      @(posedge Clk); #1;
      guard++;
    end
    checkOutput("words_drained", 32'(expQ.size()), 32'h0);
    expQ.delete();
    checkOutput("err_hold", {16'b0, ErrCount}, 32'(expErr));
    checkOutput("load_pulses", 32'(loads), (len > 0) ? 32'h1 : 32'h0);
    checkOutput("bits_consumed", 32'(enCount), 32'(nBits));
    if (len > 0) checkOutput("first_enable_latency", 32'(firstEn - acceptCyc), 32'h2);
  endtask

  initial begin
    #2;
    checkIdleReset();
    @(posedge Clk); #1;
    ARst = 1'b0;
    @(posedge Clk); #1;

    // Single full word, loopback checker.
    readyMode = 0;
    applyStimulus(32'h1, 32, 0, -1);
    checkOutput("t1_first_bits", {29'b0, lastData[2:0]}, 32'h3);
    checkOutput("t1_last_to_done", 32'(doneCyc - lastEn), 32'h1);
    checkOutput("t1_no_stall", 32'((lastEn - firstEn + 1) - enCount), 32'h0);

    // Zero seed substituted, partial word flushed.
    applyStimulus(32'h0, 8, 0, -1);
    checkOutput("t2_word", lastData, 32'h0000_00DB);
    checkOutput("t2_bits", {26'b0, lastBits}, 32'd8);

    // Slow consumer forces the generator to pause.
    readyMode = 2;
    holdLen = 40;
    applyStimulus($urandom, 96, 0, -1);
    checkOutput("t3_stalled", 32'(((lastEn - firstEn + 1) - enCount) > 0), 32'h1);

    // Every checker bit disagrees.
    readyMode = 0;
    applyStimulus($urandom, 40, 1, -1);
    checkOutput("t4_err", {16'b0, ErrCount}, 32'd40);
    checkOutput("t4_bits", {26'b0, lastBits}, 32'd8);

    // Abort mid-run at enabled bit 50.
    applyStimulus($urandom, 1000, 2, 50);
    checkOutput("t5_abort_to_done", 32'((doneCyc - abortCyc) <= 2), 32'h1);

    // Empty command.
    applyStimulus($urandom, 0, 0, -1);

    // Reset in the middle of a long run.
    expSeed = 32'hACE1_2345;
    CmdSeed = expSeed;
    CmdLen = 16'd200;
    CmdValid = 1'b1;
    @(posedge Clk); #1;
    CmdValid = 1'b0;
    for (int g = 0; g < 100 && enCount < 20; g++) begin
      @(posedge Clk); #1;
    end
    checkOutput("t6_running", {31'b0, Busy}, 32'h1);
    ARst = 1'b1;
    #1;
    checkIdleReset();
    @(posedge Clk); #1;
    ARst = 1'b0;
    @(posedge Clk); #1;

    // Randomized commands with mixed consumer behaviour and occasional aborts.
    for (int r = 0; r < 6; r++) begin
      int len, ab;
      len = int'($urandom_range(1, 150));
      readyMode = (r % 3 == 2) ? 0 : int'($urandom_range(1, 2));
      holdLen = int'($urandom_range(0, 45));
      ab = (r % 3 == 2) ? int'($urandom_range(0, len - 1)) : -1;
      applyStimulus($urandom, len, 2, ab);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
